addr_map_table: RTL and testbench

Runtime-programmable address decoder for the SoC crossbar: a table of `NumRules` start/end/index rules, written through a simple config port, translates request addresses into a slave index. It replaces fixed compile-time address maps. It sits in front of the crossbar's slave-select logic. Lookups use a registered valid/ready handshake, and per-rule lock bits freeze the map after boot.

---
 rtl/addr_map_table.sv | 186 ++++++++++++++++++
 tb/tb_addr_map_table.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_map_table.sv
// addr_map_table: runtime-programmable address decoder.
// A table of start/end/idx rules, written through a config port, maps a
// lookup address to a crossbar slave index. Lookups are answered one cycle
// after acceptance through a registered valid/ready response.
//
// Handshake semantics (both lookup channels): a transfer happens on a rising
// clock edge where valid && ready are both high. A producer holding valid
// keeps its payload stable until that edge. req_ready_o is
// !rsp_valid_o || rsp_ready_i, so a stalled response blocks new lookups.
module addr_map_table #(
    parameter int NumRules   = 16,
    parameter int NumSlaves  = 15,
    parameter int AddrWidth  = 64,
    parameter int IdxWidth   = $clog2(NumSlaves),
    parameter int DefaultIdx = 0,
    localparam int RuleWidth = (NumRules > 1) ? $clog2(NumRules) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    // config port
    input  logic                 cfg_valid_i,
    input  logic                 cfg_we_i,
    input  logic [7:0]           cfg_rule_i,
    input  logic [1:0]           cfg_field_i,
    input  logic [63:0]          cfg_wdata_i,
    output logic                 cfg_rvalid_o,
    output logic [63:0]          cfg_rdata_o,
    output logic                 cfg_err_o,
    // lookup request
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    // lookup response
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [IdxWidth-1:0]  rsp_idx_o,
    output logic                 rsp_hit_o,
    output logic [RuleWidth-1:0] rsp_rule_o
);

    localparam logic [1:0] FieldStart = 2'd0;
    localparam logic [1:0] FieldEnd   = 2'd1;
    localparam logic [1:0] FieldCtrl  = 2'd2;
    localparam logic [1:0] FieldMiss  = 2'd3;

    // rule table
    logic [AddrWidth-1:0] rule_start [NumRules];
    logic [AddrWidth-1:0] rule_end   [NumRules];
    logic [IdxWidth-1:0]  rule_idx   [NumRules];
    logic [NumRules-1:0]  rule_en;
    logic [NumRules-1:0]  rule_lock;
    logic [31:0]          miss_cnt;

    // config decode
    logic                 cfg_rule_ok;
    logic                 cfg_is_miss;
    logic                 cfg_bad;
    logic                 cfg_locked_wr;
    logic                 cfg_err;
    logic                 cfg_do_wr;
    logic                 cfg_do_clr;
    logic [RuleWidth-1:0] cfg_sel;
    logic [63:0]          cfg_rd_data;

    // lookup decode
    logic                 req_accept;
    logic                 lk_hit;
    logic [RuleWidth-1:0] lk_rule;
    logic [IdxWidth-1:0]  lk_idx;

    // Only selected slices of the write data are stored; the rest is ignored.
    logic unused_wdata;
    assign unused_wdata = ^cfg_wdata_i;

    assign req_ready_o = !rsp_valid_o || rsp_ready_i;
    assign req_accept  = req_valid_i && req_ready_o;

    // Classify the config access: range errors, lock violations, and actions.
    always_comb begin
        cfg_rule_ok   = cfg_rule_i < 8'(NumRules);
        cfg_sel       = cfg_rule_i[RuleWidth-1:0];
        cfg_is_miss   = cfg_field_i == FieldMiss;
        cfg_bad       = !cfg_rule_ok || (cfg_is_miss && cfg_rule_i != 8'd0);
        // The miss counter is not a rule field, so locks do not guard it.
        cfg_locked_wr = cfg_we_i && !cfg_is_miss && !cfg_bad && rule_lock[cfg_sel];
        cfg_err       = cfg_bad || cfg_locked_wr;
        cfg_do_wr     = cfg_valid_i && cfg_we_i && !cfg_err && !cfg_is_miss;
        cfg_do_clr    = cfg_valid_i && cfg_we_i && cfg_is_miss && !cfg_bad;
    end

    // Select the read-back value for the addressed field, zero-extended.
    always_comb begin
        cfg_rd_data = '0;
        case (cfg_field_i)
            FieldStart: cfg_rd_data = 64'(rule_start[cfg_sel]);
            FieldEnd:   cfg_rd_data = 64'(rule_end[cfg_sel]);
            FieldCtrl: begin
                cfg_rd_data[IdxWidth-1:0] = rule_idx[cfg_sel];
                cfg_rd_data[32]           = rule_en[cfg_sel];
                cfg_rd_data[33]           = rule_lock[cfg_sel];
            end
            default:    cfg_rd_data = 64'(miss_cnt);
        endcase
    end

    // Priority match: scanning from the top down lets the lowest rule win.
    // A rule with end <= start can never satisfy start <= addr < end.
    always_comb begin
        lk_hit  = 1'b0;
        lk_rule = '0;
        lk_idx  = IdxWidth'(DefaultIdx);
        for (int r = NumRules - 1; r >= 0; r--) begin
            if (rule_en[r] && req_addr_i >= rule_start[r] && req_addr_i < rule_end[r]) begin
                lk_hit  = 1'b1;
                lk_rule = RuleWidth'(r);
                lk_idx  = rule_idx[r];
            end
        end
    end

    // Rule table storage; locked rules reject every write until reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NumRules; r++) begin
                rule_start[r] <= '0;
                rule_end[r]   <= '0;
                rule_idx[r]   <= '0;
            end
            rule_en   <= '0;
            rule_lock <= '0;
        end else if (cfg_do_wr) begin
            case (cfg_field_i)
                FieldStart: rule_start[cfg_sel] <= cfg_wdata_i[AddrWidth-1:0];
                FieldEnd:   rule_end[cfg_sel]   <= cfg_wdata_i[AddrWidth-1:0];
                FieldCtrl: begin
                    rule_idx[cfg_sel]  <= cfg_wdata_i[IdxWidth-1:0];
                    rule_en[cfg_sel]   <= cfg_wdata_i[32];
                    rule_lock[cfg_sel] <= cfg_wdata_i[33];
                end
                default: ;
            endcase
        end
    end

    // Saturating miss counter; a clear wins over a coincident miss.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            miss_cnt <= '0;
        end else if (cfg_do_clr) begin
            miss_cnt <= '0;
        end else if (req_accept && !lk_hit && miss_cnt != 32'hFFFF_FFFF) begin
            miss_cnt <= miss_cnt + 32'd1;
        end
    end

    // Config response: one-cycle pulse for every access, data only on good reads.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_rvalid_o <= 1'b0;
            cfg_rdata_o  <= '0;
            cfg_err_o    <= 1'b0;
        end else begin
            cfg_rvalid_o <= cfg_valid_i;
            cfg_err_o    <= cfg_valid_i && cfg_err;
            cfg_rdata_o  <= (cfg_valid_i && !cfg_we_i && !cfg_err) ? cfg_rd_data : '0;
        end
    end

    // Registered lookup response, held while the consumer stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_o <= 1'b0;
            rsp_idx_o   <= '0;
            rsp_hit_o   <= 1'b0;
            rsp_rule_o  <= '0;
        end else if (req_accept) begin
            rsp_valid_o <= 1'b1;
            rsp_idx_o   <= lk_idx;
            rsp_hit_o   <= lk_hit;
            rsp_rule_o  <= lk_rule;
        end else if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_addr_map_table.sv
// Directed bench for addr_map_table with expected-response queues.
module tb_addr_map_table;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cfg_valid_i = 1'b0;
    logic        cfg_we_i = 1'b0;
    logic [7:0]  cfg_rule_i = '0;
    logic [1:0]  cfg_field_i = '0;
    logic [63:0] cfg_wdata_i = '0;
    logic        cfg_rvalid_o;
    logic [63:0] cfg_rdata_o;
    logic        cfg_err_o;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [63:0] req_addr_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [3:0]  rsp_idx_o;
    logic        rsp_hit_o;
    logic [3:0]  rsp_rule_o;

    // expected responses: lookup {hit, rule, idx}; config {err, rdata}
    logic [8:0]  exp_rsp_q[$];
    logic [64:0] exp_cfg_q[$];
    logic [8:0]  mon_rsp_e;
    logic [64:0] mon_cfg_e;
    int n_vec = 0;
    int n_miss = 0;

    addr_map_table dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cfg_valid_i(cfg_valid_i), .cfg_we_i(cfg_we_i), .cfg_rule_i(cfg_rule_i),
        .cfg_field_i(cfg_field_i), .cfg_wdata_i(cfg_wdata_i),
        .cfg_rvalid_o(cfg_rvalid_o), .cfg_rdata_o(cfg_rdata_o), .cfg_err_o(cfg_err_o),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_idx_o(rsp_idx_o),
        .rsp_hit_o(rsp_hit_o), .rsp_rule_o(rsp_rule_o)
    );

    // clock
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // monitor: pops and compares whenever the DUT presents a response
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (rsp_valid_o && rsp_ready_i) begin
                if (exp_rsp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL rsp_unexpected: got %0h, expected none", {rsp_hit_o, rsp_rule_o, rsp_idx_o});
                end else begin
                    mon_rsp_e = exp_rsp_q.pop_front();
                    check("rsp", {56'd0, rsp_hit_o, rsp_rule_o, rsp_idx_o}, {56'd0, mon_rsp_e});
                end
            end
            if (cfg_rvalid_o) begin
                if (exp_cfg_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL cfg_unexpected: got %0h, expected none", {cfg_err_o, cfg_rdata_o});
                end else begin
                    mon_cfg_e = exp_cfg_q.pop_front();
                    check("cfg", {cfg_err_o, cfg_rdata_o}, mon_cfg_e);
                end
            end
        end
    end

    // driver tasks
    task automatic set_cfg(input logic we, input logic [7:0] rule, input logic [1:0] field,
                           input logic [63:0] wdata, input logic err, input logic [63:0] rdata);
        cfg_valid_i = 1'b1;
        cfg_we_i    = we;
        cfg_rule_i  = rule;
        cfg_field_i = field;
        cfg_wdata_i = wdata;
        exp_cfg_q.push_back({err, rdata});
    endtask

    task automatic set_req(input logic [63:0] addr, input logic hit, input logic [3:0] rule,
                           input logic [3:0] idx);
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        exp_rsp_q.push_back({hit, rule, idx});
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        cfg_valid_i = 1'b0;
        cfg_we_i    = 1'b0;
        req_valid_i = 1'b0;
    endtask

    task automatic wr(input logic [7:0] rule, input logic [1:0] field, input logic [63:0] data,
                      input logic err);
        set_cfg(1'b1, rule, field, data, err, 64'd0);
        tick();
    endtask

    task automatic rd(input logic [7:0] rule, input logic [1:0] field, input logic err,
                      input logic [63:0] data);
        set_cfg(1'b0, rule, field, 64'd0, err, data);
        tick();
    endtask

    task automatic look(input logic [63:0] addr, input logic hit, input logic [3:0] rule,
                        input logic [3:0] idx);
        set_req(addr, hit, rule, idx);
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (exp_rsp_q.size() != 0 || exp_cfg_q.size() != 0); i++)
            @(posedge clk_i);
        #1;
        check("drain_rsp", 65'(exp_rsp_q.size()), 65'd0);
        check("drain_cfg", 65'(exp_cfg_q.size()), 65'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 65'(req_ready_o), 65'd1);
        check({tag, "_rsp_valid"}, 65'(rsp_valid_o), 65'd0);
        check({tag, "_rsp_fields"}, 65'({rsp_hit_o, rsp_rule_o, rsp_idx_o}), 65'd0);
        check({tag, "_cfg_rvalid"}, 65'(cfg_rvalid_o), 65'd0);
        check({tag, "_cfg_rdata"}, 65'(cfg_rdata_o), 65'd0);
        check({tag, "_cfg_err"}, 65'(cfg_err_o), 65'd0);
    endtask

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        check_reset_outputs("reset");

        // program and decode
        wr(8'd0, 2'd0, 64'h8000_0000, 1'b0);
        wr(8'd0, 2'd1, 64'hA000_0000, 1'b0);
        wr(8'd0, 2'd2, 64'h1_0000_000E, 1'b0);
        look(64'h9FFF_FFFF, 1'b1, 4'd0, 4'd14);
        look(64'hA000_0000, 1'b0, 4'd0, 4'd0);
        look(64'h8000_0000, 1'b1, 4'd0, 4'd14);
        rd(8'd0, 2'd3, 1'b0, 64'd1);
        rd(8'd0, 2'd0, 1'b0, 64'h8000_0000);
        rd(8'd0, 2'd2, 1'b0, 64'h1_0000_000E);
        // ctrl truncation: only idx, enable and lock survive; start=end=0 never matches
        wr(8'd5, 2'd2, 64'hFFFF_FFFD_FFFF_FFF5, 1'b0);
        rd(8'd5, 2'd2, 1'b0, 64'h1_0000_0005);

        // priority
        wr(8'd3, 2'd0, 64'h1000, 1'b0);
        wr(8'd3, 2'd1, 64'h2000, 1'b0);
        wr(8'd3, 2'd2, 64'h1_0000_0005, 1'b0);
        wr(8'd1, 2'd0, 64'h1800, 1'b0);
        wr(8'd1, 2'd1, 64'h3000, 1'b0);
        wr(8'd1, 2'd2, 64'h1_0000_0007, 1'b0);
        look(64'h1900, 1'b1, 4'd1, 4'd7);
        look(64'h1200, 1'b1, 4'd3, 4'd5);
        look(64'h2800, 1'b1, 4'd1, 4'd7);
        look(64'h3000, 1'b0, 4'd0, 4'd0);

        // lock
        wr(8'd2, 2'd2, 64'h2_0000_0003, 1'b0);
        wr(8'd2, 2'd0, 64'h40, 1'b1);
        wr(8'd2, 2'd2, 64'h0, 1'b1);
        rd(8'd2, 2'd0, 1'b0, 64'h0);
        rd(8'd2, 2'd2, 1'b0, 64'h2_0000_0003);

        // same-cycle config and lookup
        wr(8'd4, 2'd0, 64'h5000, 1'b0);
        wr(8'd4, 2'd1, 64'h6000, 1'b0);
        set_cfg(1'b1, 8'd4, 2'd2, 64'h1_0000_0009, 1'b0, 64'd0);
        set_req(64'h5500, 1'b0, 4'd0, 4'd0);
        tick();
        look(64'h5500, 1'b1, 4'd4, 4'd9);

        // bad config accesses
        rd(8'd16, 2'd0, 1'b1, 64'd0);
        rd(8'd1, 2'd3, 1'b1, 64'd0);
        wr(8'd200, 2'd0, 64'h1234, 1'b1);
        rd(8'd0, 2'd3, 1'b0, 64'd3);

        // counter clear coincident with a miss
        set_cfg(1'b1, 8'd0, 2'd3, 64'hDEAD, 1'b0, 64'd0);
        set_req(64'h7000_0000, 1'b0, 4'd0, 4'd0);
        tick();
        rd(8'd0, 2'd3, 1'b0, 64'd0);
        look(64'h7000_0000, 1'b0, 4'd0, 4'd0);
        rd(8'd0, 2'd3, 1'b0, 64'd1);

        // backpressure
        rsp_ready_i = 1'b0;
        set_req(64'h1900, 1'b1, 4'd1, 4'd7);
        @(posedge clk_i);
        #1 req_addr_i = 64'h1200;
        repeat (5) begin
            check("bp_req_ready", 65'(req_ready_o), 65'd0);
            check("bp_rsp_valid", 65'(rsp_valid_o), 65'd1);
            check("bp_rsp_hold", 65'({rsp_hit_o, rsp_rule_o, rsp_idx_o}), 65'({1'b1, 4'd1, 4'd7}));
            @(posedge clk_i);
            #1;
        end
        exp_rsp_q.push_back({1'b1, 4'd3, 4'd5});
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
        @(posedge clk_i);
        #1 check("bp_one_extra", 65'(rsp_valid_o), 65'd0);
        drain();

        // reset clears the lock and the table
        rst_ni = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        check_reset_outputs("reset2");
        wr(8'd2, 2'd0, 64'h40, 1'b0);
        rd(8'd2, 2'd0, 1'b0, 64'h40);
        rd(8'd0, 2'd2, 1'b0, 64'h0);
        rd(8'd0, 2'd3, 1'b0, 64'h0);
        look(64'h9000_0000, 1'b0, 4'd0, 4'd0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
